// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for the iterative shift/rotate sequencer.
interface shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [AMT_W-1:0] in_amt;
  logic             in_rot;
  logic             in_left;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_a, in_amt, in_rot, in_left, in_sign, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_a, in_amt, in_rot, in_left, in_sign, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_seq.sv
// Iterative shift/rotate sequencer: one 1-bit shifter step per cycle, registered result
// presented over a valid/ready handshake.
module shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3,
  parameter int unsigned AMT_W = 5
) (
  input logic        clk,
  input logic        rst,
  shift_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             rot_q, rot_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;

  logic [SHW:0]     eff;
  logic [WIDTH-1:0] step;

  // Rotates wrap modulo WIDTH; shifts saturate at WIDTH steps, which fully drains the operand.
  always_comb begin
    eff = '0;
    if (bus.in_rot) begin
      eff = {1'b0, bus.in_amt[SHW-1:0]};
    end else if (bus.in_amt >= AMT_W'(WIDTH)) begin
      eff = (SHW+1)'(WIDTH);
    end else begin
      eff = (SHW+1)'(bus.in_amt);
    end
  end

  // Single shifter instance with the shift amount fixed at one.
  always_comb begin
    step = data_q;
    if (rot_q) begin
      step = left_q ? {data_q[WIDTH-2:0], data_q[WIDTH-1]} : {data_q[0], data_q[WIDTH-1:1]};
    end else if (left_q) begin
      step = {data_q[WIDTH-2:0], 1'b0};
    end else begin
      step = {sign_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    left_d  = left_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_a;
          rot_d   = bus.in_rot;
          left_d  = bus.in_left;
          sign_d  = bus.in_sign;
          cnt_d   = eff;
          state_d = (eff == '0) ? StDone : StBusy;
        end
      end
      StBusy: begin
        data_d = step;
        cnt_d  = cnt_q - (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(1)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
